fdc_seek_read: RTL and testbench

- Controller-side sequencer that drives the floppy drive model's select, motor and step inputs.
- Seeks the head to a requested track and waits for the drive to report ready.
- Locates the requested sector by watching the drive's sector header/data, index and byte-clock outputs, then emits one strobe per data byte.
- Sits between the FDC command logic and the floppy drive model; it is the initiator of the drive's interface.

---
 rtl/fdc_seek_read_if.sv | 38 +++
 rtl/fdc_seek_read.sv | 207 ++++++++++++++++++++
 tb/tb_fdc_seek_read.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdc_seek_read_if.sv
// Command-side and drive-side signals of the seek/read sequencer.
// master = sequencer (drives the floppy), slave = command logic plus drive model.
interface fdc_seek_read_if;
  logic        cmd_start;
  logic [6:0]  cmd_track;
  logic [3:0]  cmd_sector;
  logic [10:0] sector_len;
  logic        dclk_en;
  logic [6:0]  track;
  logic [3:0]  sector;
  logic        sector_hdr;
  logic        sector_data;
  logic        ready;
  logic        index;
  logic        select;
  logic        motor_on;
  logic        step_in;
  logic        step_out;
  logic        busy;
  logic        byte_valid;
  logic [10:0] byte_idx;
  logic        done;
  logic [1:0]  err;

  modport master (
    input  cmd_start, cmd_track, cmd_sector, sector_len,
    input  dclk_en, track, sector, sector_hdr, sector_data, ready, index,
    output select, motor_on, step_in, step_out, busy,
    output byte_valid, byte_idx, done, err
  );

  modport slave (
    output cmd_start, cmd_track, cmd_sector, sector_len,
    output dclk_en, track, sector, sector_hdr, sector_data, ready, index,
    input  select, motor_on, step_in, step_out, busy,
    input  byte_valid, byte_idx, done, err
  );
endinterface

// File: rtl/fdc_seek_read.sv
// Floppy seek/read sequencer: steps the head to the target track, waits for ready,
// finds the sector header and strobes out each data byte. All outputs are registered.
module fdc_seek_read #(
  parameter int SYS_CLK            = 8000000,
  parameter int STEP_PULSE_CLKS    = 32,
  parameter int STEP_RATE_CLKS     = 48000,
  parameter int TRACKS             = 85,
  parameter int SEARCH_REVS        = 5,
  parameter int MOTOR_IDLE_REVS    = 9,
  parameter int READY_TIMEOUT_CLKS = 8000000
) (
  input  logic           clk,
  input  logic           reset,
  fdc_seek_read_if.master bus
);

  if (SYS_CLK <= 0 || STEP_RATE_CLKS < STEP_PULSE_CLKS + 2 || STEP_PULSE_CLKS < 1 ||
      READY_TIMEOUT_CLKS < 2 || SEARCH_REVS < 1 || MOTOR_IDLE_REVS < 1) begin : g_bad_cfg
    $error("fdc_seek_read: inconsistent timing parameters");
  end

  // The one-cycle SEEK_CHECK sits inside the step period, hence RATE-2.
  localparam logic [15:0] PULSE_LAST = 16'(STEP_PULSE_CLKS - 1);
  localparam logic [15:0] RATE_LAST  = 16'(STEP_RATE_CLKS - 2);
  // FINISH plus the registered done take two cycles, so done lands exactly
  // READY_TIMEOUT_CLKS after WAIT_READY entry.
  localparam logic [23:0] TMO_LAST   = 24'(READY_TIMEOUT_CLKS - 2);
  localparam logic [3:0]  SREV_LAST  = 4'(SEARCH_REVS - 1);
  localparam logic [3:0]  IREV_LAST  = 4'(MOTOR_IDLE_REVS - 1);
  localparam logic [7:0]  TRACK_LIM  = 8'(TRACKS);

  typedef enum logic [2:0] {
    S_IDLE, S_SEEK_CHECK, S_STEP_PULSE, S_STEP_WAIT,
    S_WAIT_READY, S_SEARCH, S_READ, S_FINISH
  } state_t;

  state_t      state, state_n;
  logic [1:0]  err_code, err_n;
  logic [6:0]  tgt_track;
  logic [3:0]  tgt_sector;
  logic [10:0] tgt_len;
  logic        dir_in;
  logic        idx_q;
  logic        data_seen;
  logic [15:0] step_tmr;
  logic [23:0] tmo;
  logic [3:0]  rev_cnt;
  logic [3:0]  idle_rev;
  logic [10:0] byte_cnt;

  logic        select_r, motor_r, step_in_r, step_out_r, busy_r, byte_valid_r, done_r;
  logic [10:0] byte_idx_r;
  logic [1:0]  err_r;

  logic idx_fall, hdr_match, byte_hit, track_bad, last_byte;

  assign idx_fall  = idx_q & ~bus.index;
  assign hdr_match = bus.sector_hdr && (bus.sector == tgt_sector);
  assign byte_hit  = bus.dclk_en && bus.sector_data;
  assign track_bad = {1'b0, bus.cmd_track} >= TRACK_LIM;
  assign last_byte = byte_cnt == (tgt_len - 11'd1);

  always_comb begin
    state_n = state;
    err_n   = err_code;
    case (state)
      S_IDLE:
        if (bus.cmd_start) begin
          if (track_bad) begin
            state_n = S_FINISH;
            err_n   = 2'd3;
          end else begin
            state_n = S_SEEK_CHECK;
          end
        end
      S_SEEK_CHECK: state_n = (bus.track == tgt_track) ? S_WAIT_READY : S_STEP_PULSE;
      S_STEP_PULSE: if (step_tmr >= PULSE_LAST) state_n = S_STEP_WAIT;
      S_STEP_WAIT:  if (step_tmr >= RATE_LAST) state_n = S_SEEK_CHECK;
      S_WAIT_READY:
        if (bus.ready) begin
          state_n = S_SEARCH;
        end else if (tmo >= TMO_LAST) begin
          state_n = S_FINISH;
          err_n   = 2'd2;
        end
      S_SEARCH:
        if (hdr_match) begin
          state_n = S_READ;
        end else if (idx_fall && rev_cnt >= SREV_LAST) begin
          state_n = S_FINISH;
          err_n   = 2'd1;
        end
      S_READ:
        if (byte_hit && last_byte) begin
          state_n = S_FINISH;
          err_n   = 2'd0;
        end else if (data_seen && !bus.sector_data) begin
          state_n = S_FINISH;
          err_n   = 2'd1;
        end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      err_code     <= 2'd0;
      tgt_track    <= '0;
      tgt_sector   <= '0;
      tgt_len      <= '0;
      dir_in       <= 1'b0;
      idx_q        <= 1'b0;
      data_seen    <= 1'b0;
      step_tmr     <= '0;
      tmo          <= '0;
      rev_cnt      <= '0;
      idle_rev     <= '0;
      byte_cnt     <= '0;
      select_r     <= 1'b0;
      motor_r      <= 1'b0;
      step_in_r    <= 1'b0;
      step_out_r   <= 1'b0;
      busy_r       <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_idx_r   <= '0;
      done_r       <= 1'b0;
      err_r        <= 2'd0;
    end else begin
      state        <= state_n;
      err_code     <= err_n;
      idx_q        <= bus.index;
      done_r       <= 1'b0;
      byte_valid_r <= 1'b0;
      // Step lines trail the state by one cycle, so they never rise with select.
      step_in_r    <= (state == S_STEP_PULSE) && dir_in;
      step_out_r   <= (state == S_STEP_PULSE) && !dir_in;
      case (state)
        S_IDLE:
          if (bus.cmd_start) begin
            tgt_track  <= bus.cmd_track;
            tgt_sector <= bus.cmd_sector;
            tgt_len    <= bus.sector_len;
            select_r   <= 1'b1;
            motor_r    <= 1'b1;
            busy_r     <= 1'b1;
            idle_rev   <= '0;
          end else if (motor_r && idx_fall) begin
            if (idle_rev >= IREV_LAST) begin
              motor_r  <= 1'b0;
              select_r <= 1'b0;
              idle_rev <= '0;
            end else begin
              idle_rev <= idle_rev + 4'd1;
            end
          end
        S_SEEK_CHECK: begin
          dir_in   <= bus.track > tgt_track;
          step_tmr <= '0;
          tmo      <= '0;
        end
        S_STEP_PULSE, S_STEP_WAIT:
          if (step_tmr != '1) step_tmr <= step_tmr + 16'd1;
        S_WAIT_READY: begin
          if (tmo != '1) tmo <= tmo + 24'd1;
          rev_cnt <= '0;
        end
        S_SEARCH: begin
          byte_cnt  <= '0;
          data_seen <= 1'b0;
          if (idx_fall && !hdr_match && rev_cnt != '1) rev_cnt <= rev_cnt + 4'd1;
        end
        S_READ: begin
          if (bus.sector_data) data_seen <= 1'b1;
          if (byte_hit) begin
            byte_valid_r <= 1'b1;
            byte_idx_r   <= byte_cnt;
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;
          end
        end
        S_FINISH: begin
          done_r   <= 1'b1;
          err_r    <= err_code;
          busy_r   <= 1'b0;
          idle_rev <= '0;
          if (err_code == 2'd2) begin
            motor_r  <= 1'b0;
            select_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.select     = select_r;
  assign bus.motor_on   = motor_r;
  assign bus.step_in    = step_in_r;
  assign bus.step_out   = step_out_r;
  assign bus.busy       = busy_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.byte_idx   = byte_idx_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;

endmodule

// File: tb/tb_fdc_seek_read.sv
// Scoreboard bench: a rotating-disk drive model feeds the sequencer; expected byte
// strobes and completions are queued at command issue and popped by a monitor.
module tb_fdc_seek_read;
  localparam int P      = 4;
  localparam int RATE   = 24;
  localparam int TRK    = 85;
  localparam int SREVS  = 5;
  localparam int IREVS  = 9;
  localparam int TMO    = 300;
  localparam int SPT    = 9;
  localparam int SETTLE = 10;

  typedef struct {
    bit is_done;
    int val;
    int exp_cyc;
    int n_out;
    int n_in;
    int trk;
    bit motor;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  fdc_seek_read_if bus();

  fdc_seek_read #(
    .SYS_CLK(8000000), .STEP_PULSE_CLKS(P), .STEP_RATE_CLKS(RATE), .TRACKS(TRK),
    .SEARCH_REVS(SREVS), .MOTOR_IDLE_REVS(IREVS), .READY_TIMEOUT_CLKS(TMO)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  initial forever #5 clk = ~clk;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   drv_track = 0, drv_len = 8, idx_falls = 0;
  bit   force_nr = 1'b0;
  int   n_out = 0, n_in = 0, last_rise = -1, issue_cyc = 0;

  initial forever @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(string name, int act, int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive model: 8-cycle preamble (index low for 2), then SPT slots of
  // 4 header + 2 gap + 2*len data (byte clock on odd cycles) + 2 gap.
  initial begin
    int pos, slot, q, o, settle;
    bit pso, psi;
    pos = 2; pso = 0; psi = 0; settle = 0;
    bus.index = 1'b1; bus.track = '0; bus.sector = '0; bus.sector_hdr = 1'b0;
    bus.sector_data = 1'b0; bus.dclk_en = 1'b0; bus.ready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.step_out && !pso) begin
        if (drv_track < TRK - 1) drv_track++;
        settle = SETTLE;
      end
      if (bus.step_in && !psi) begin
        if (drv_track > 0) drv_track--;
        settle = SETTLE;
      end
      pso = bus.step_out; psi = bus.step_in;
      if (settle > 0) settle--;
      slot = 8 + 2 * drv_len;
      pos++;
      if (pos >= 8 + SPT * slot) pos = 0;
      if (pos == 0) idx_falls++;
      bus.index = (pos >= 2);
      bus.track = 7'(drv_track);
      bus.ready = bus.motor_on && bus.select && !force_nr && settle == 0;
      bus.sector_hdr = 1'b0; bus.sector_data = 1'b0; bus.dclk_en = 1'b0; bus.sector = '0;
      if (pos >= 8) begin
        q = pos - 8;
        o = q % slot;
        bus.sector      = 4'(q / slot);
        bus.sector_hdr  = (o < 4);
        bus.sector_data = (o >= 6) && (o < 6 + 2 * drv_len);
        bus.dclk_en     = bus.sector_data && ((o - 6) % 2 == 1);
      end
    end
  end

  // Monitor: step pulse shape plus scoreboard pops on byte_valid / done.
  initial begin
    exp_t e;
    bit st, pst;
    int hi_start;
    pst = 0; hi_start = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pst = 0;
      end else begin
        st = bus.step_in | bus.step_out;
        if (st && !pst) begin
          chk("step_excl", int'(bus.step_in & bus.step_out), 0);
          if (bus.step_out) n_out++; else n_in++;
          if (last_rise >= 0) chk("step_period", cyc - last_rise, RATE);
          last_rise = cyc;
          hi_start = cyc;
        end
        if (!st && pst) chk("step_width", cyc - hi_start, P);
        pst = st;
        if (bus.byte_valid) begin
          if (sb.size() == 0 || sb[0].is_done) begin
            fail("stray_byte", int'(bus.byte_idx), -1);
          end else begin
            e = sb.pop_front();
            chk("byte_idx", int'(bus.byte_idx), e.val);
            chk("busy_in_read", int'(bus.busy), 1);
          end
        end
        if (bus.done) begin
          while (sb.size() > 0 && !sb[0].is_done) begin
            e = sb.pop_front();
            fail("missing_byte", -1, e.val);
          end
          if (sb.size() == 0) begin
            fail("stray_done", int'(bus.err), -1);
          end else begin
            e = sb.pop_front();
            chk("err", int'(bus.err), e.val);
            chk("busy_at_done", int'(bus.busy), 0);
            chk("steps_out", n_out, e.n_out);
            chk("steps_in", n_in, e.n_in);
            chk("final_track", drv_track, e.trk);
            chk("motor_at_done", int'(bus.motor_on), int'(e.motor));
            chk("select_at_done", int'(bus.select), int'(e.motor));
            if (e.exp_cyc >= 0) chk("done_latency", cyc - issue_cyc, e.exp_cyc);
          end
        end
      end
    end
  end

  function automatic int ref_err(int tgt, int sec, bit nr);
    if (tgt >= TRK) return 3;
    if (nr) return 2;
    if (sec >= SPT) return 1;
    return 0;
  endfunction

  task automatic issue(int start, int tgt, int sec, int len, bit nr);
    exp_t e;
    int er;
    @(negedge clk);
    drv_track = start; drv_len = len; force_nr = nr;
    er = ref_err(tgt, sec, nr);
    if (er == 0)
      for (int i = 0; i < len; i++) begin
        e.is_done = 0; e.val = i; e.exp_cyc = -1; e.n_out = 0; e.n_in = 0; e.trk = 0; e.motor = 0;
        sb.push_back(e);
      end
    e.is_done = 1;
    e.val     = er;
    e.exp_cyc = (er == 3) ? 2 : (er == 2 && start == tgt) ? 2 + TMO : -1;
    e.n_out   = (er != 3 && tgt > start) ? tgt - start : 0;
    e.n_in    = (er != 3 && start > tgt) ? start - tgt : 0;
    e.trk     = (er == 3) ? start : tgt;
    e.motor   = (er != 2);
    sb.push_back(e);
    n_out = 0; n_in = 0; last_rise = -1;
    bus.cmd_track = 7'(tgt); bus.cmd_sector = 4'(sec); bus.sector_len = 11'(len);
    bus.cmd_start = 1'b1;
    issue_cyc = cyc;
    @(negedge clk);
    bus.cmd_start = 1'b0;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      fail("timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_select"}, int'(bus.select), 0);
    chk({tag, "_motor"}, int'(bus.motor_on), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_step"}, int'(bus.step_in | bus.step_out), 0);
    chk({tag, "_bvalid"}, int'(bus.byte_valid), 0);
    chk({tag, "_bidx"}, int'(bus.byte_idx), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"}, int'(bus.err), 0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: got %0d cycles expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, st, tg;
    bus.cmd_start = 1'b0; bus.cmd_track = '0; bus.cmd_sector = '0; bus.sector_len = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    issue(0, 0, 3, 512, 0); wait_done(25000);
    issue(0, 3, 5, 8, 0);   wait_done(5000);
    issue(3, 1, 0, 8, 0);   wait_done(5000);
    issue(1, 1, 12, 8, 0);  wait_done(5000);

    // Not-ready timeout, with a start request thrown in while busy.
    issue(2, 2, 0, 8, 1);
    repeat (50) @(negedge clk);
    chk("busy_hold", int'(bus.busy), 1);
    bus.cmd_track = 7'd7; bus.cmd_start = 1'b1;
    @(negedge clk);
    bus.cmd_start = 1'b0;
    wait_done(2000);

    issue(2, 90, 0, 8, 0); wait_done(100);

    // Motor idle-off after an ok read: still on after 8 index pulses, off after 9.
    issue(2, 2, 2, 8, 0); wait_done(5000);
    base = idx_falls; n = 0;
    while (idx_falls < base + IREVS - 1 && n < 5000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("motor_idle_8", int'(bus.motor_on), 1);
    while (idx_falls < base + IREVS && n < 5000) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("motor_idle_9", int'(bus.motor_on), 0);
    chk("select_idle_9", int'(bus.select), 0);

    for (int k = 0; k < 8; k++) begin
      st = int'($urandom_range(0, 10));
      tg = ($urandom_range(0, 7) == 0) ? 85 + int'($urandom_range(0, 42)) : int'($urandom_range(0, 10));
      issue(st, tg, int'($urandom_range(0, 10)), int'($urandom_range(1, 12)),
            $urandom_range(0, 9) == 0);
      wait_done(8000);
    end

    // Reset in the middle of a sector read abandons it silently.
    issue(0, 0, 1, 12, 0);
    n = 0;
    while (!(bus.byte_valid && bus.byte_idx == 11'd4) && n < 5000) begin @(negedge clk); n++; end
    chk("reached_read", int'(n < 5000), 1);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_all_zero("midread_reset");
    reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
